// File: rtl/fifo_flush_pkg.sv
// Shared types and default parameters for the flushable nibble FIFO write-side scheduler.
package fifo_flush_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 4;
  localparam int DEF_FLUSH_HOLD  = 2;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FLUSH      = 2'd1,
    ST_WAIT_EMPTY = 2'd2,
    ST_DONE       = 2'd3
  } sched_state_e;

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Requester, flush-control and FIFO write-port signals of the write scheduler.
// master = scheduler side, slave = requesters/FIFO side.
interface fifo_wr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      flush_req_i;
  logic                      flush_done_o;
  logic                      flush_timeout_o;
  logic                      fifo_full_i;
  logic                      fifo_empty_i;
  logic                      fifo_wr_valid_o;
  logic [DATA_W-1:0]         fifo_wr_data_o;
  logic                      fifo_flush_o;
  logic [IDX_W-1:0]          grant_id_o;

  modport master (
    input  req_valid_i, req_data_i, flush_req_i, fifo_full_i, fifo_empty_i,
    output req_ready_o, flush_done_o, flush_timeout_o, fifo_wr_valid_o,
           fifo_wr_data_o, fifo_flush_o, grant_id_o
  );

  modport slave (
    output req_valid_i, req_data_i, flush_req_i, fifo_full_i, fifo_empty_i,
    input  req_ready_o, flush_done_o, flush_timeout_o, fifo_wr_valid_o,
           fifo_wr_data_o, fifo_flush_o, grant_id_o
  );
endinterface

// File: rtl/fifo_wr_sched_arb.sv
// Combinational round-robin arbiter: first valid request at or after ptr_i wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (en_i && !found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IDX_W-1:0];
      end
    end
    if (found) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Round-robin write-port scheduler with flush sequencing for the nibble FIFO.
// Optional WAIT_EMPTY timeout is compiled in with FIFO_WR_SCHED_TIMEOUT_EN.
//   state         | meaning
//   ST_IDLE       | arbitrate writes; flush_req_i starts a flush
//   ST_FLUSH      | fifo_flush_o high for FLUSH_HOLD cycles
//   ST_WAIT_EMPTY | wait for fifo_empty_i (or timeout)
//   ST_DONE       | one-cycle flush_done_o pulse
module fifo_wr_sched
  import fifo_flush_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FLUSH_HOLD  = DEF_FLUSH_HOLD,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  fifo_wr_sched_if.master  bus
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(FLUSH_HOLD + 1);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 arb_en;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     win_idx;
  logic                 wr_fire;
  logic [DATA_W-1:0]    wr_data;
  logic                 timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i   (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.flush_req_i) begin
          state_d = ST_FLUSH;
          hold_d  = HOLD_W'(FLUSH_HOLD - 1);
        end else if (wr_fire) begin
          ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      ST_FLUSH: begin
        if (hold_q == '0) state_d = ST_WAIT_EMPTY;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      ST_WAIT_EMPTY: begin
        if (bus.fifo_empty_i || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // rst_n gates the grant so nothing is offered while reset is held
  always_comb begin
    arb_en  = rst_n && (state_q == ST_IDLE) && !bus.flush_req_i && !bus.fifo_full_i;
    wr_fire = |grant;
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) wr_data = wr_data | bus.req_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign bus.req_ready_o     = grant;
  assign bus.grant_id_o      = win_idx;
  assign bus.fifo_wr_valid_o = wr_fire;
  assign bus.fifo_wr_data_o  = wr_data;
  assign bus.fifo_flush_o    = (state_q == ST_FLUSH);
  assign bus.flush_done_o    = (state_q == ST_DONE);

`ifdef FIFO_WR_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;

  // counter is preloaded outside WAIT_EMPTY so the first dwell cycle counts
  always_comb begin
    to_cnt_d    = to_cnt_q;
    to_flag_d   = to_flag_q;
    timeout_hit = 1'b0;
    if (state_q != ST_WAIT_EMPTY) begin
      to_cnt_d = TO_W'(TIMEOUT_CYC - 1);
    end else if (!bus.fifo_empty_i) begin
      if (to_cnt_q == '0) begin
        timeout_hit = 1'b1;
        to_flag_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q - TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign bus.flush_timeout_o = to_flag_q;
`else
  assign timeout_hit         = 1'b0;
  assign bus.flush_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Self-checking bench for fifo_wr_sched: directed test-plan steps followed by a
// randomized phase, all compared against a cycle-age reference model.
module tb_fifo_wr_sched;

  localparam int N    = 4;
  localparam int DW   = 4;
  localparam int HOLD = 2;
  localparam int TOC  = 8;
`ifdef FIFO_WR_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  fifo_wr_sched_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  fifo_wr_sched #(.NUM_REQ(N), .DATA_W(DW), .FLUSH_HOLD(HOLD), .TIMEOUT_CYC(TOC)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: pointer plus "cycles since flush accepted"
  int m_ptr;
  bit m_busy;
  int m_age;
  bit m_done;
  int m_wait;
  bit m_to;

  logic [N-1:0]  o_rdy;
  logic [DW-1:0] o_data;
  logic [1:0]    o_gid;
  logic          o_wv, o_fl, o_dn, o_to;

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_age = 0; m_done = 0; m_wait = 0; m_to = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                      input logic full, input logic flush, input logic empty);
    int win;
    logic [N-1:0]  e_rdy;
    logic [DW-1:0] e_data;
    @(negedge clk_sys);
    rst_n            = rst;
    bus.req_valid_i  = v;
    bus.req_data_i   = d;
    bus.fifo_full_i  = full;
    bus.flush_req_i  = flush;
    bus.fifo_empty_i = empty;
    if (!rst) model_reset();
    #1;
    win = -1;
    if (rst && !m_busy && !flush && !full) begin
      for (int j = 0; j < N; j++) begin
        if (win < 0 && v[(m_ptr + j) % N]) win = (m_ptr + j) % N;
      end
    end
    e_rdy  = (win >= 0) ? N'(1) << win : '0;
    e_data = (win >= 0) ? DW'(d >> (win * DW)) : '0;
    o_rdy  = bus.req_ready_o;
    o_data = bus.fifo_wr_data_o;
    o_gid  = bus.grant_id_o;
    o_wv   = bus.fifo_wr_valid_o;
    o_fl   = bus.fifo_flush_o;
    o_dn   = bus.flush_done_o;
    o_to   = bus.flush_timeout_o;
    chk("req_ready",  32'(o_rdy),  32'(e_rdy));
    chk("wr_valid",   32'(o_wv),   32'(win >= 0));
    chk("wr_data",    32'(o_data), 32'(e_data));
    chk("grant_id",   32'(o_gid),  (win >= 0) ? 32'(win) : 32'd0);
    chk("flush_o",    32'(o_fl),   32'(m_busy && m_age <= HOLD));
    chk("flush_done", 32'(o_dn),   32'(m_busy && m_done));
    chk("timeout",    32'(o_to),   32'(m_to));
    @(posedge clk_sys);
    if (rst) begin
      if (!m_busy) begin
        if (flush) begin
          m_busy = 1; m_age = 1; m_done = 0; m_wait = 0;
        end else if (win >= 0) begin
          m_ptr = (win + 1) % N;
        end
      end else if (m_done) begin
        m_busy = 0;
      end else if (m_age <= HOLD) begin
        m_age++;
      end else begin
        m_wait++;
        if (empty) m_done = 1;
        else if (TO_EN && m_wait == TOC) begin
          m_to = 1; m_done = 1;
        end
      end
    end
  endtask

  initial begin
    logic [N*DW-1:0] rr_d;
    logic [DW-1:0]   rr_exp [5];
    logic [4:0]      fl_exp, dn_exp, wv_exp;
    int dn_cnt;

    model_reset();
    bus.req_valid_i = '1; bus.req_data_i = '0; bus.fifo_full_i = 0;
    bus.flush_req_i = 0;  bus.fifo_empty_i = 1;

    // reset held two cycles with every requester valid
    rr_d = {4'hD, 4'h5, 4'h3, 4'hA};
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'hF, rr_d, 1'b0, 1'b0, 1'b1);
      chk("rst_ready", 32'(o_rdy), 32'd0);
    end

    // all four valid: strict rotation with wrap
    rr_exp[0] = 4'hA; rr_exp[1] = 4'h3; rr_exp[2] = 4'h5; rr_exp[3] = 4'hD; rr_exp[4] = 4'hA;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'hF, rr_d, 1'b0, 1'b0, 1'b1);
      chk("rr_data", 32'(o_data), 32'(rr_exp[i]));
      chk("rr_gid",  32'(o_gid),  32'(i % N));
    end

    // requesters 1 and 3 with FIFO full for three cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1010, rr_d, 1'b1, 1'b0, 1'b1);
      chk("full_nowr", 32'(o_wv), 32'd0);
    end
    step(1'b1, 4'b1010, rr_d, 1'b0, 1'b0, 1'b1);
    chk("full_res1", 32'(o_gid), 32'd1);
    step(1'b1, 4'b1010, rr_d, 1'b0, 1'b0, 1'b1);
    chk("full_res3", 32'(o_gid), 32'd3);

    // single-cycle flush pulse, FIFO already empty
    step(1'b1, 4'hF, rr_d, 1'b0, 1'b1, 1'b1);
    chk("flush_n_wr", 32'(o_wv), 32'd0);
    fl_exp = 5'b00011; dn_exp = 5'b01000; wv_exp = 5'b10000;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'hF, rr_d, 1'b0, 1'b0, 1'b1);
      chk("pulse_flush", 32'(o_fl), 32'(fl_exp[k]));
      chk("pulse_done",  32'(o_dn), 32'(dn_exp[k]));
      chk("pulse_wr",    32'(o_wv), 32'(wv_exp[k]));
    end

    // flush held across DONE: two back-to-back sequences, no write in between
    dn_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 4'hF, rr_d, 1'b0, 1'b1, 1'b1);
      chk("held_nowr", 32'(o_wv), 32'd0);
      if (o_dn) dn_cnt++;
    end
    chk("held_dones", 32'(dn_cnt), 32'd2);
    step(1'b1, 4'hF, rr_d, 1'b0, 1'b0, 1'b1);
    chk("held_after", 32'(o_wv), 32'd1);

    if (TO_EN) begin
      step(1'b1, 4'h0, rr_d, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 14; k++) begin
        step(1'b1, 4'h0, rr_d, 1'b0, 1'b0, 1'b0);
        if (k == 10) chk("to_before", 32'(o_to), 32'd0);
        if (k == 11) begin
          chk("to_set",  32'(o_to), 32'd1);
          chk("to_done", 32'(o_dn), 32'd1);
        end
        if (k == 14) chk("to_sticky", 32'(o_to), 32'd1);
      end
      step(1'b0, 4'h0, rr_d, 1'b0, 1'b0, 1'b0);
      chk("to_cleared", 32'(o_to), 32'd0);
    end

    // randomized traffic, flushes, full/empty and occasional mid-run reset
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 100) != 0, N'($urandom), (N*DW)'($urandom),
           ($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
